fetch_unit: RTL

- F-stage control block of the 5-stage pipeline.
- Owns the program counter and drives the instruction memory read address.
- Captures the returned instruction into the IF/ID pipeline register, together with PC+4, for the D stage.
- Handles stalls from hazard detection, redirects from branch/jump resolution, and fetch halt on syscall.

---
 rtl/fetch_unit_pkg.sv | 33 +++
 rtl/fetch_unit_pc_register.sv | 26 ++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: default encodings, alignment helper and the IF/ID record.
// Also consumed by the decoder and hazard unit.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0040_0000;
  localparam logic [31:0] NOP_INSN_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] HALT_INSN_DEFAULT = 32'h0000_000C;
  localparam logic [31:0] WORD_ALIGN_MASK   = 32'hFFFF_FFFC;
  localparam logic [31:0] INSN_BYTES        = 32'd4;

  typedef enum logic [0:0] {
    StFetch,
    StHalted
  } fetch_state_e;

  typedef enum logic [1:0] {
    ActRedirect,
    ActStall,
    ActHaltHold,
    ActFetch
  } fetch_action_e;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_register.sv
// Program counter register with asynchronous reset and load enable.
module fetch_unit_pc_register
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_next_pc,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_next_pc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// F-stage control: owns the PC, drives instruction memory and fills the IF/ID register.
// Handles stall, redirect and syscall halt with priority redirect > stall > halted > fetch.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSN  = NOP_INSN_DEFAULT,
  parameter logic [31:0] HALT_INSN = HALT_INSN_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectTarget,
  input  logic [31:0] memInstruction,
  output logic [31:0] readAddress,
  output logic [31:0] ifidInstruction,
  output logic [31:0] ifidPcPlus4,
  output logic        ifidValid,
  output logic        halted,
  output logic [31:0] fetchCount
);

  fetch_state_e  r_state;
  fetch_state_e  w_state_d;
  fetch_action_e w_action;
  ifid_t         r_ifid;
  ifid_t         w_ifid_d;
  logic          w_ifid_load;
  logic [31:0]   r_fetch_count;
  logic          w_count_inc;
  logic          w_pc_load;
  logic [31:0]   w_next_pc;
  logic [31:0]   w_pc;
  logic [31:0]   w_pc_plus4;
  logic          w_is_halt;

  localparam ifid_t IfidBubble = '{insn: NOP_INSN, pc_plus4: 32'd0, valid: 1'b0};

  fetch_unit_pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc_register (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_pc_load),
    .i_next_pc(w_next_pc),
    .o_pc     (w_pc)
  );

  assign w_pc_plus4 = w_pc + INSN_BYTES;
  assign w_is_halt  = (memInstruction == HALT_INSN);

  always_comb begin
    if (redirect) begin
      w_action = ActRedirect;
    end else if (stall) begin
      w_action = ActStall;
    end else if (r_state == StHalted) begin
      w_action = ActHaltHold;
    end else begin
      w_action = ActFetch;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next state: a redirect cancels a speculative halt
  always_comb begin
    w_state_d = r_state;
    unique case (w_action)
      ActRedirect: w_state_d = StFetch;
      ActStall:    w_state_d = r_state;
      ActHaltHold: w_state_d = StHalted;
      ActFetch:    w_state_d = w_is_halt ? StHalted : StFetch;
      default:     w_state_d = r_state;
    endcase
  end

  // FSM outputs: PC update, IF/ID load and counter increment
  always_comb begin
    w_pc_load   = 1'b0;
    w_next_pc   = w_pc;
    w_ifid_load = 1'b0;
    w_ifid_d    = IfidBubble;
    w_count_inc = 1'b0;
    unique case (w_action)
      ActRedirect: begin
        w_pc_load   = 1'b1;
        w_next_pc   = word_align(redirectTarget);
        w_ifid_load = 1'b1;
      end
      ActStall: begin
        w_pc_load = 1'b0;
      end
      ActHaltHold: begin
        w_ifid_load = 1'b1;
      end
      ActFetch: begin
        // The syscall itself is delivered, but the PC parks on it.
        w_pc_load   = !w_is_halt;
        w_next_pc   = w_pc_plus4;
        w_ifid_load = 1'b1;
        w_ifid_d    = '{insn: memInstruction, pc_plus4: w_pc_plus4, valid: 1'b1};
        w_count_inc = 1'b1;
      end
      default: begin
        w_pc_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ifid <= IfidBubble;
    end else if (w_ifid_load) begin
      r_ifid <= w_ifid_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_count <= 32'd0;
    end else if (w_count_inc) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign readAddress     = w_pc;
  assign ifidInstruction = r_ifid.insn;
  assign ifidPcPlus4     = r_ifid.pc_plus4;
  assign ifidValid       = r_ifid.valid;
  assign halted          = (r_state == StHalted);
  assign fetchCount      = r_fetch_count;

endmodule
